// File: rtl/rv_multicycle_ctrl.sv
// Purpose: multi-cycle RV32I sequencer (fetch/decode/exec/mem/wb) driving every datapath enable.
// Latency: 3 cycles for branch/LUI/JAL, 4 for ALU/store, 5 for load, plus one per memory wait cycle.
// Backpressure: mem_req/mem_we/mem_addr_sel are held until mem_ready; TIMEOUT stalled cycles trap (cause 2).
module rv_multicycle_ctrl #(
  parameter int ALU_OP_W = 4,
  parameter int TIMEOUT  = 16,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_ready,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  input  logic                alu_zero,
  input  logic                alu_lt,
  output logic                mem_req,
  output logic                mem_we,
  output logic                mem_addr_sel,
  output logic                ir_load,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                reg_write_en,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_src_b,
  output logic [1:0]          mem_to_reg,
  output logic                trap,
  output logic [1:0]          trap_cause,
  output logic                retire,
  output logic [CNT_W-1:0]    instret
);

  // Major opcodes accepted by the decoder
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  // ALU operation encoding seen by the datapath
  localparam logic [ALU_OP_W-1:0] ALU_ADD  = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_AND  = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] ALU_OR   = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = ALU_OP_W'(4);
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = ALU_OP_W'(5);
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = ALU_OP_W'(6);
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = ALU_OP_W'(7);
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = ALU_OP_W'(8);
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = ALU_OP_W'(9);

  localparam logic [1:0] PC_SEQ    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JAL    = 2'd2;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_LINK = 2'd2;
  localparam logic [1:0] WB_UIMM = 2'd3;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  // Stall count value at which the next low-ready cycle is the TIMEOUT-th one
  localparam logic [7:0] STALL_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_LUI, CLS_JAL
  } cls_e;

  typedef struct packed {
    logic                legal;
    cls_e                cls;
    logic [ALU_OP_W-1:0] alu_op;
    logic                alu_src_b;
  } dec_t;

  state_e              state;
  state_e              state_nxt;
  dec_t                dec;
  logic                br_taken;
  logic                mem_phase;
  logic                stall_expire;
  logic [7:0]          stall_cnt;
  logic [1:0]          trap_cause_q;
  logic [CNT_W-1:0]    instret_q;

  // funct3 -> ALU op for register and immediate arithmetic (shift-right defaults to logical)
  function automatic logic [ALU_OP_W-1:0] f3_alu_op(input logic [2:0] f3);
    logic [ALU_OP_W-1:0] op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Instruction decode from the latched IR fields: class, legality and ALU control
  always_comb begin
    dec = '0;
    case (opcode)
      OPC_OP: begin
        dec.cls = CLS_ALU;
        if (funct7 == F7_BASE) begin
          dec.legal  = 1'b1;
          dec.alu_op = f3_alu_op(funct3);
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          dec.legal  = 1'b1;
          dec.alu_op = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          dec.legal  = 1'b1;
          dec.alu_op = ALU_SRA;
        end
      end
      OPC_OPIMM: begin
        dec.cls       = CLS_ALU;
        dec.alu_src_b = 1'b1;
        dec.alu_op    = f3_alu_op(funct3);
        case (funct3)
          3'b001: dec.legal = (funct7 == F7_BASE);
          3'b101: begin
            dec.legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
            if (funct7 == F7_ALT) dec.alu_op = ALU_SRA;
          end
          default: dec.legal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec.cls       = CLS_LOAD;
        dec.legal     = (funct3 == 3'b010);
        dec.alu_src_b = 1'b1;
      end
      OPC_STORE: begin
        dec.cls       = CLS_STORE;
        dec.legal     = (funct3 == 3'b010);
        dec.alu_src_b = 1'b1;
      end
      OPC_BRANCH: begin
        // funct3[2] selects compare-by-subtract (eq/ne) vs set-less-than; funct3[1] picks unsigned
        dec.cls   = CLS_BRANCH;
        dec.legal = (funct3[2:1] != 2'b01);
        if (!funct3[2])     dec.alu_op = ALU_SUB;
        else if (funct3[1]) dec.alu_op = ALU_SLTU;
        else                dec.alu_op = ALU_SLT;
      end
      OPC_LUI: begin
        dec.cls   = CLS_LUI;
        dec.legal = 1'b1;
      end
      OPC_JAL: begin
        dec.cls   = CLS_JAL;
        dec.legal = 1'b1;
      end
      default: ;
    endcase
  end

  // funct3[0] inverts the sense: bne/bge/bgeu are the complements of beq/blt/bltu
  assign br_taken     = (funct3[2] ? alu_lt : alu_zero) ^ funct3[0];
  assign mem_phase    = (state == S_FETCH) || (state == S_MEM);
  assign stall_expire = mem_phase && !mem_ready && (stall_cnt == STALL_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  // Next-state logic; a handshake in the expiring cycle wins over the timeout
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: begin
        if (mem_ready)         state_nxt = S_DECODE;
        else if (stall_expire) state_nxt = S_TRAP;
      end
      S_DECODE: state_nxt = dec.legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        case (dec.cls)
          CLS_ALU:             state_nxt = S_WB;
          CLS_LOAD, CLS_STORE: state_nxt = S_MEM;
          default:             state_nxt = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (mem_ready)         state_nxt = (dec.cls == CLS_LOAD) ? S_WB : S_FETCH;
        else if (stall_expire) state_nxt = S_TRAP;
      end
      S_WB:    state_nxt = S_FETCH;
      S_TRAP:  state_nxt = S_TRAP;
      default: state_nxt = S_FETCH;
    endcase
  end

  // Consecutive stalled-request counter; restarts on handshake or any state change
  always_ff @(posedge clk) begin
    if (rst)                                                 stall_cnt <= 8'd0;
    else if (mem_phase && !mem_ready && state_nxt == state)  stall_cnt <= stall_cnt + 8'd1;
    else                                                     stall_cnt <= 8'd0;
  end

  // Capture why we entered TRAP; only DECODE can trap for an illegal encoding
  always_ff @(posedge clk) begin
    if (rst)
      trap_cause_q <= 2'd0;
    else if (state != S_TRAP && state_nxt == S_TRAP)
      trap_cause_q <= (state == S_DECODE) ? CAUSE_ILLEGAL : CAUSE_TIMEOUT;
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk) begin
    if (rst)         instret_q <= '0;
    else if (retire) instret_q <= instret_q + CNT_W'(1);
  end

  // Output decode from state, IR fields and mem_ready; everything forced low during reset
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_load      = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PC_SEQ;
    reg_write_en = 1'b0;
    alu_op       = ALU_ADD;
    alu_src_b    = 1'b0;
    mem_to_reg   = WB_ALU;
    trap         = 1'b0;
    trap_cause   = 2'd0;
    retire       = 1'b0;
    instret      = '0;
    if (!rst) begin
      instret = instret_q;
      case (state)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_load  = 1'b1;
            pc_write = 1'b1;
            pc_src   = PC_SEQ;
          end
        end
        S_EXEC: begin
          alu_op    = dec.alu_op;
          alu_src_b = dec.alu_src_b;
          case (dec.cls)
            CLS_BRANCH: begin
              if (br_taken) begin
                pc_write = 1'b1;
                pc_src   = PC_BRANCH;
              end
              retire = 1'b1;
            end
            CLS_LUI: begin
              reg_write_en = 1'b1;
              mem_to_reg   = WB_UIMM;
              retire       = 1'b1;
            end
            CLS_JAL: begin
              reg_write_en = 1'b1;
              mem_to_reg   = WB_LINK;
              pc_write     = 1'b1;
              pc_src       = PC_JAL;
              retire       = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          // Keep the address adder live so the memory address stays valid while stalled
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = (dec.cls == CLS_STORE);
          alu_op       = dec.alu_op;
          alu_src_b    = dec.alu_src_b;
          retire       = mem_ready && (dec.cls == CLS_STORE);
        end
        S_WB: begin
          alu_op       = dec.alu_op;
          alu_src_b    = dec.alu_src_b;
          reg_write_en = 1'b1;
          mem_to_reg   = (dec.cls == CLS_LOAD) ? WB_MEM : WB_ALU;
          retire       = 1'b1;
        end
        S_TRAP: begin
          trap       = 1'b1;
          trap_cause = trap_cause_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/rv_multicycle_ctrl.md
# rv_multicycle_ctrl

Multi-cycle FSM controller for the RV32I core; it replaces the single-cycle combinational decoder. It sequences fetch, decode, execute, memory and writeback over a shared instruction/data memory port with a valid/ready handshake, and drives every datapath enable. It adds full branch decode, SLT/SLTU, memory-stall timeout, illegal-instruction trapping and a retired-instruction counter.

## Interface
- ALU_OP_W, 4, alu_op width; must be ≥4.
- TIMEOUT, 16, consecutive stalled cycles on the memory port before a bus-error trap; range 2..255.
- CNT_W, 32, instret counter width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- mem_ready  in  1  memory accepts or returns this cycle.
- opcode  in  7  IR[6:0].
- funct3  in  3  IR[14:12].
- funct7  in  7  IR[31:25].
- alu_zero  in  1  ALU result == 0.
- alu_lt  in  1  ALU result[0], valid for SLT/SLTU.
- mem_req  out  1  memory request, held until accepted.
- mem_we  out  1  store request.
- mem_addr_sel  out  1  0: PC, 1: ALU result.
- ir_load  out  1  latch instruction word and old_pc.
- pc_write  out  1  PC update enable.
- pc_src  out  2  0: PC+4, 1: old_pc+imm_b, 2: old_pc+imm_j.
- reg_write_en  out  1  register-file write.
- alu_op  out  ALU_OP_W  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU.
- alu_src_b  out  1  0: rs2, 1: immediate.
- mem_to_reg  out  2  0: ALU, 1: memory data, 2: PC+4 (from old_pc), 3: U-immediate.
- trap  out  1  sticky halt flag.
- trap_cause  out  2  0: none, 1: illegal instruction, 2: bus timeout.
- retire  out  1  one-cycle pulse per completed instruction.
- instret  out  CNT_W  retired-instruction count.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Reset state is FETCH.
- FETCH:
  - mem_req=1, mem_addr_sel=0.
  - When mem_ready=1: ir_load=1, pc_write=1, pc_src=0, then go to DECODE.
- DECODE:
  - Supported opcodes: 0110011, 0010011, 0000011 (funct3 010), 0100011 (funct3 010), 1100011, 0110111, 1101111.
  - R-type: legal only for funct7 0x00 with any funct3, or funct7 0x20 with funct3 000/101.
  - I-type: funct3 000/100/110/111 (addi, xori, ori, andi); 001 (slli) with funct7=0x00; 101 with funct7 0x00 (srli) or 0x20 (srai); 010/011 map to SLT/SLTU.
  - Branch funct3 010/011 is illegal.
  - Any unsupported encoding → TRAP with cause 1. Otherwise → EXEC.
- EXEC (alu_op and alu_src_b driven from decode):
  - R/I-type: → WB.
  - Load/store: alu_op=ADD, alu_src_b=1, → MEM.
  - Branch: beq/bne use SUB (taken on alu_zero / !alu_zero); blt/bge use SLT (taken on alu_lt / !alu_lt); bltu/bgeu use SLTU (same flags). If taken: pc_write=1, pc_src=1. Then retire and → FETCH.
  - LUI: reg_write_en=1, mem_to_reg=3, retire, → FETCH.
  - JAL: reg_write_en=1, mem_to_reg=2, pc_write=1, pc_src=2, retire, → FETCH.
- MEM:
  - mem_req=1, mem_addr_sel=1, mem_we=1 for stores.
  - On mem_ready: store retires and → FETCH; load → WB.
- WB: reg_write_en=1, mem_to_reg=1 for loads and 0 otherwise, retire, → FETCH.
- TRAP: all enables 0, trap=1, trap_cause held. Exit only via rst.
- Stall counter:
  - 8-bit, counts consecutive cycles in FETCH/MEM with mem_req=1 and mem_ready=0.
  - Clears on handshake or on state change.
  - Reaching TIMEOUT → TRAP with cause 2. The request is dropped in the TRAP cycle.
- instret increments by 1 on each retire, wrapping modulo 2^CNT_W.

## Timing
- While rst=1, all outputs are 0. rst has priority over every transition, including mid-stall and TRAP.
- The first mem_req appears in the cycle after rst falls.
- Outputs are combinational functions of the registered state, the decode inputs and mem_ready. There is no output register.
- Cycles per instruction with zero-wait memory:
  - branch, LUI, JAL: 3
  - R/I-type, store: 4
  - load: 5
- Each wait cycle on the memory port adds 1.
- mem_req, mem_we and mem_addr_sel stay stable from assertion until the cycle mem_ready=1 (inclusive).
- retire and instret update coincide with the final cycle of the instruction. instret shows the new value one cycle later.
- A timeout fires on the TIMEOUT-th consecutive low-ready cycle. mem_ready=1 in that same cycle wins: the handshake completes and no trap is raised.

## Test plan
- add x3,x1,x2 with mem_ready tied 1 → states FETCH, DECODE, EXEC, WB; reg_write_en=1 in WB with alu_op=0; retire pulse on cycle 4; instret=1.
- lw with data ready delayed 3 cycles → MEM holds mem_req=1, mem_addr_sel=1 for 4 cycles; WB has mem_to_reg=1; total 8 cycles.
- bltu with alu_lt=1, then bgeu with alu_lt=1 → first gives pc_write=1, pc_src=1, alu_op=9; second gives pc_write=0 in EXEC.
- opcode 0x73 → TRAP after DECODE, trap_cause=1, no reg or mem writes. A later rst pulse returns to FETCH with instret=0.
- mem_ready held 0 with TIMEOUT=16 → trap_cause=2 after exactly 16 FETCH cycles. A variant with mem_ready=1 on the 16th cycle gives no trap.
- CNT_W=4, 16 LUI instructions → instret wraps from 15 to 0.
